// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among N_REQ requesters.
// Each grant reads up to BURST words. The read data is tagged with the owner's index.
module fifo_rd_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                     r_clk,
    input  logic                     r_rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     fifo_empty,
    input  logic [DW-1:0]            fifo_rdata,
    output logic                     fifo_rd_en,
    output logic [N_REQ-1:0]         gnt,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(N_REQ)-1:0] out_id,
    output logic                     busy,
    output logic [1:0]               dbg_state_o
);

    localparam int               IW      = $clog2(N_REQ);
    localparam logic [3:0]       CNT_MAX = 4'(BURST);
    localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    owner_q;
    logic             out_valid_q;
    logic [IW-1:0]    out_id_q;

    logic             rd_en;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    scan_idx;

    // out_valid is a one-cycle strobe: out_data/out_id are meaningful only while it is high.
    // There is no back-pressure, so the consumer must take the word in that cycle.
    always_comb begin
        rd_en     = (state_q == S_BURST) && req[owner_q] && !fifo_empty && (cnt_q < CNT_MAX);
        cnt_d     = cnt_q + 4'd1;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        // The scan runs from the farthest candidate to the nearest one, so the nearest
        // requesting index at or after rr_ptr is the last value written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_q + IW'(k);
            if (req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= rd_en;
            if (rd_en) begin
                out_id_q <= owner_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_q    <= ONE_HOT << win_idx;
                        owner_q  <= win_idx;
                        rr_ptr_q <= win_idx + IW'(1);
                        cnt_q    <= '0;
                        state_q  <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (rd_en) begin
                        cnt_q <= cnt_d;
                    end
                    // Ownership ends when the owner drops its request or when the last word is read.
                    if (!req[owner_q] || (rd_en && cnt_d == CNT_MAX)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    gnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en  = rd_en;
    assign gnt         = gnt_q;
    assign out_valid   = out_valid_q;
    assign out_data    = fifo_rdata;
    assign out_id      = out_id_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule
